pll_reset_sequencer: RTL and testbench

Controls the reset and lock qualification of the board PLL that generates the 50 MHz fabric clock from the 25 MHz reference. It runs on the free-running reference clock and holds the PLL in reset for a fixed time after power-up. It then waits for lock with a timeout and retries a bounded number of times. Downstream logic, such as the SATA link/PHY reset release, gets a single qualified `clk_ready` only after lock has been stable for a programmable period.

---
 rtl/pll_reset_sequencer.sv | 134 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock qualifier on refclk; optional PLL_SEQ_AUTO_RECOVER_EN re-acquires lock loss in READY.
// Latency: registered outputs, one cycle after the decision; lock path adds a 2-flop synchronizer.
// Backpressure: none; relock_req acts immediately from any state.
module pll_reset_sequencer #(
  parameter int RST_CYCLES   = 250,
  parameter int LOCK_TIMEOUT = 25000,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       clk_ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] state
);

  localparam logic [2:0] S_RESET_PLL  = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_STABLE_CHK = 3'd2;
  localparam logic [2:0] S_READY      = 3'd3;
  localparam logic [2:0] S_FAULT      = 3'd4;

  localparam int CNT_MAX = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_STB  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]       MAX_R    = MAX_RETRIES[1:0];

  logic [1:0]       sync_q;
  logic             lock_s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TMO_W-1:0] tmo, tmo_nxt, tmo_inc;
  logic [1:0]       retry_nxt;
  logic [2:0]       state_nxt;
  logic             timeout;

  always_ff @(posedge refclk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], pll_locked};
  end
  assign lock_s = sync_q[1];

  // tmo saturates so a lock seen on the last allowed cycle still times out in STABLE_CHK
  assign timeout = (tmo == TMO_LAST);
  assign tmo_inc = timeout ? tmo : tmo + TMO_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmo_nxt   = tmo;
    retry_nxt = retry_count;
    if (relock_req) begin
      state_nxt = S_RESET_PLL;
      cnt_nxt   = CNT_RST;
      retry_nxt = 2'd0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == '0) begin
            state_nxt = S_WAIT_LOCK;
            tmo_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        S_WAIT_LOCK, S_STABLE_CHK: begin
          tmo_nxt = tmo_inc;
          if (state == S_STABLE_CHK && lock_s && cnt == '0) begin
            state_nxt = S_READY;
          end else if (state == S_WAIT_LOCK && lock_s) begin
            state_nxt = S_STABLE_CHK;
            cnt_nxt   = CNT_STB;
          end else if (timeout) begin
            if (retry_count < MAX_R) begin
              retry_nxt = retry_count + 2'd1;
              state_nxt = S_RESET_PLL;
              cnt_nxt   = CNT_RST;
            end else begin
              state_nxt = S_FAULT;
            end
          end else if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        S_READY: begin
          if (!lock_s) begin
`ifdef PLL_SEQ_AUTO_RECOVER_EN
            state_nxt = S_RESET_PLL;
            cnt_nxt   = CNT_RST;
            retry_nxt = 2'd0;
`else
            state_nxt = S_FAULT;
`endif
          end
        end
        S_FAULT: state_nxt = S_FAULT;
        default: begin
          state_nxt = S_RESET_PLL;
          cnt_nxt   = CNT_RST;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_RESET_PLL;
      cnt         <= CNT_RST;
      tmo         <= '0;
      retry_count <= 2'd0;
      pll_rst     <= 1'b1;
      clk_ready   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tmo         <= tmo_nxt;
      retry_count <= retry_nxt;
      pll_rst     <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
      clk_ready   <= (state_nxt == S_READY);
      fault       <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expectations are queued per cycle, a negedge monitor compares.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, clk_ready, fault;
  logic [1:0] retry_count;
  logic [2:0] state;

  pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .clk_ready(clk_ready), .fault(fault),
    .retry_count(retry_count), .state(state)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] exp;
    logic [7:0] mask;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] M_RST = 8'h80;
  localparam logic [7:0] M_RDY = 8'h40;
  localparam logic [7:0] M_FLT = 8'h20;
  localparam logic [7:0] M_RTY = 8'h18;
  localparam logic [7:0] M_ST  = 8'h07;
  localparam logic [7:0] M_ALL = 8'hFF;

  logic [7:0] obs;
  assign obs = {pll_rst, clk_ready, fault, retry_count, state};

  // Sorted insert keeps the queue ordered by the cycle in which the check applies.
  task automatic ck(input int c, input string n, input logic pr, input logic rdy,
                    input logic flt, input logic [1:0] rt, input logic [2:0] st,
                    input logic [7:0] m);
    chk_t e;
    int   i;
    e.cyc  = c;
    e.name = n;
    e.exp  = {pr, rdy, flt, rt, st};
    e.mask = m;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge refclk);
      #1;
    end
  endtask

  always @(negedge refclk) begin
    chk_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d never sampled", e.name, e.cyc);
      end else if (((obs ^ e.exp) & e.mask) !== 8'h00) begin
        errors++;
        $display("FAIL %s @cyc %0d: got %b want %b (mask %b)", e.name, cyc, obs, e.exp, e.mask);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Nominal lock: rst released in cycle 3, lock raised 5 cycles after pll_rst falls.
    ck(3,  "reset_state",  1, 0, 0, 2'd0, 3'd0, M_ALL);
    for (int c = 4; c <= 6; c++) ck(c, "rst_hold", 1, 0, 0, 2'd0, 3'd0, M_RST);
    ck(7,  "rst_release",  0, 0, 0, 2'd0, 3'd1, M_RST | M_ST);
    ck(14, "wait_lock",    0, 0, 0, 2'd0, 3'd1, M_ST);
    ck(15, "stable_entry", 0, 0, 0, 2'd0, 3'd2, M_ST);
    ck(22, "pre_ready",    0, 0, 0, 2'd0, 3'd2, M_RDY | M_ST);
    ck(23, "ready",        0, 1, 0, 2'd0, 3'd3, M_ALL);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(12);
    pll_locked = 1'b1;

    // Lock loss in READY: clk_ready drops 3 cycles after pll_locked.
    ck(28, "loss_still_ready", 0, 1, 0, 2'd0, 3'd3, M_RDY);
`ifdef PLL_SEQ_AUTO_RECOVER_EN
    ck(29, "loss_recover", 1, 0, 0, 2'd0, 3'd0, M_ALL);
    ck(35, "recover_wait", 0, 0, 0, 2'd0, 3'd1, M_ALL);
`else
    ck(29, "loss_fault",   1, 0, 1, 2'd0, 3'd4, M_ALL);
    ck(35, "fault_stuck",  1, 0, 1, 2'd0, 3'd4, M_ALL);
`endif
    wait_cyc(26);
    pll_locked = 1'b0;

    // Relock then exhaustion with pll_locked held low: three pll_rst pulses, then FAULT.
    ck(37,  "relock",      1, 0, 0, 2'd0, 3'd0, M_ALL);
    ck(40,  "relock_hold", 1, 0, 0, 2'd0, 3'd0, M_RST);
    ck(41,  "attempt1",    0, 0, 0, 2'd0, 3'd1, M_RST | M_ST);
    ck(60,  "pre_tmo1",    0, 0, 0, 2'd0, 3'd1, M_RST | M_ST);
    ck(61,  "tmo1",        1, 0, 0, 2'd1, 3'd0, M_ALL);
    ck(64,  "retry_hold",  1, 0, 0, 2'd1, 3'd0, M_RST);
    ck(65,  "retry_rel",   0, 0, 0, 2'd1, 3'd1, M_RST | M_ST);
    ck(85,  "tmo2",        1, 0, 0, 2'd2, 3'd0, M_ALL);
    ck(108, "pre_fault",   0, 0, 0, 2'd2, 3'd1, M_ALL);
    ck(109, "exhausted",   1, 0, 1, 2'd2, 3'd4, M_ALL);
    ck(111, "fault_hold",  1, 0, 1, 2'd2, 3'd4, M_ALL);
    wait_cyc(36);
    relock_req = 1'b1;
    wait_cyc(37);
    relock_req = 1'b0;

    // Relock from FAULT, then retry once and lock during the second attempt.
    ck(113, "relock_fault", 1, 0, 0, 2'd0, 3'd0, M_ALL);
    ck(137, "retry_tmo",    1, 0, 0, 2'd1, 3'd0, M_ALL);
    ck(141, "retry_wait",   0, 0, 0, 2'd1, 3'd1, M_RST | M_RTY | M_ST);
    ck(153, "retry_pre",    0, 0, 0, 2'd1, 3'd2, M_RDY | M_ST);
    ck(154, "retry_ready",  0, 1, 0, 2'd1, 3'd3, M_ALL);
    wait_cyc(112);
    relock_req = 1'b1;
    wait_cyc(113);
    relock_req = 1'b0;
    wait_cyc(143);
    pll_locked = 1'b1;

    // Chatter with period 6 from pll_rst release: no READY, timeout 20 cycles after release.
    ck(161, "relock_from_ready", 1, 0, 0, 2'd0, 3'd0, M_ALL);
    for (int c = 165; c <= 184; c++) ck(c, "chatter_no_ready", 0, 0, 0, 2'd0, 3'd0, M_RDY);
    ck(168, "chatter_stable",  0, 0, 0, 2'd0, 3'd2, M_ST);
    ck(171, "chatter_drop",    0, 0, 0, 2'd0, 3'd1, M_ST);
    ck(184, "chatter_pre_tmo", 0, 0, 0, 2'd0, 3'd1, M_RST | M_RTY);
    ck(185, "chatter_tmo",     1, 0, 0, 2'd1, 3'd0, M_ALL);
    wait_cyc(160);
    relock_req = 1'b1;
    pll_locked = 1'b0;
    wait_cyc(161);
    relock_req = 1'b0;
    for (int c = 165; c <= 184; c++) begin
      wait_cyc(c);
      pll_locked = (((c - 165) / 3) % 2) == 0;
    end
    wait_cyc(185);
    pll_locked = 1'b0;

    // relock_req coinciding with a WAIT_LOCK timeout wins over the retry.
    ck(208, "pre_tmo_relock",   0, 0, 0, 2'd1, 3'd1, M_ALL);
    ck(209, "relock_vs_tmo",    1, 0, 0, 2'd0, 3'd0, M_ALL);
    ck(212, "post_relock_hold", 1, 0, 0, 2'd0, 3'd0, M_ALL);
    ck(213, "post_relock_wait", 0, 0, 0, 2'd0, 3'd1, M_ALL);
    wait_cyc(208);
    relock_req = 1'b1;
    wait_cyc(209);
    relock_req = 1'b0;

    wait_cyc(216);
    while (sb.size() > 0) begin
      chk_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: check for cycle %0d left unchecked", e.name, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
